// File: rtl/medidor_tempo_if.sv
// Bus between the main control unit and the key-hold duration meter.
// The master drives the start and key level; the slave returns the measured duration.
interface medidor_tempo_if;
    logic       iniciar;
    logic       tecla_ativa;
    logic [3:0] tempo;
    logic [3:0] tempo_baixo;
    logic       meio_metro;
    logic       pronto;
    logic       medindo;

    modport master (
        output iniciar,
        output tecla_ativa,
        input  tempo,
        input  tempo_baixo,
        input  meio_metro,
        input  pronto,
        input  medindo
    );

    modport slave (
        input  iniciar,
        input  tecla_ativa,
        output tempo,
        output tempo_baixo,
        output meio_metro,
        output pronto,
        output medindo
    );
endinterface

// File: rtl/medidor_tempo.sv
// Measures how long a note key is held, in metronome units (rounded up, rounded down,
// and half-unit flag), publishing a one-cycle pronto pulse when the result is loaded.
module medidor_tempo #(
    parameter int unsigned CICLOS_METRO = 1000
) (
    input logic            clock,
    input logic            reset,
    medidor_tempo_if.slave bus
);
    localparam int unsigned        LARGURA = $clog2(CICLOS_METRO);
    localparam logic [LARGURA-1:0] ULTIMO  = LARGURA'(CICLOS_METRO - 1);
    localparam logic [LARGURA-1:0] METADE  = LARGURA'(CICLOS_METRO / 2);

    typedef enum logic [1:0] {Ocioso, Medindo, Pronto} estado_t;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] ciclos_q, ciclos_d;
    logic [3:0]         unidades_q, unidades_d;
    logic               sat_q, sat_d;
    logic [3:0]         tempo_q, tempo_d;
    logic [3:0]         tempo_baixo_q, tempo_baixo_d;
    logic               meio_q, meio_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= Ocioso;
            ciclos_q      <= '0;
            unidades_q    <= '0;
            sat_q         <= 1'b0;
            tempo_q       <= '0;
            tempo_baixo_q <= '0;
            meio_q        <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            ciclos_q      <= ciclos_d;
            unidades_q    <= unidades_d;
            sat_q         <= sat_d;
            tempo_q       <= tempo_d;
            tempo_baixo_q <= tempo_baixo_d;
            meio_q        <= meio_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        ciclos_d      = ciclos_q;
        unidades_d    = unidades_q;
        sat_d         = sat_q;
        tempo_d       = tempo_q;
        tempo_baixo_d = tempo_baixo_q;
        meio_d        = meio_q;

        case (estado_q)
            Ocioso: begin
                ciclos_d   = '0;
                unidades_d = '0;
                sat_d      = 1'b0;
                if (bus.iniciar) begin
                    estado_d = Medindo;
                end
            end
            Medindo: begin
                if (bus.tecla_ativa) begin
                    // Once saturated the counters freeze so the result reads as exactly 15.
                    if (!sat_q) begin
                        if (ciclos_q == ULTIMO) begin
                            ciclos_d = '0;
                            if (unidades_q == 4'd14) begin
                                unidades_d = 4'd15;
                                sat_d      = 1'b1;
                            end else begin
                                unidades_d = unidades_q + 4'd1;
                            end
                        end else begin
                            ciclos_d = ciclos_q + 1'b1;
                        end
                    end
                end else begin
                    tempo_baixo_d = unidades_q;
                    if ((ciclos_q != '0) && !sat_q && (unidades_q != 4'd15)) begin
                        tempo_d = unidades_q + 4'd1;
                    end else begin
                        tempo_d = unidades_q;
                    end
                    meio_d   = (ciclos_q >= METADE) && !sat_q;
                    estado_d = Pronto;
                end
            end
            Pronto: begin
                estado_d = Ocioso;
            end
            default: begin
                estado_d = Ocioso;
            end
        endcase
    end

    assign bus.tempo       = tempo_q;
    assign bus.tempo_baixo = tempo_baixo_q;
    assign bus.meio_metro  = meio_q;
    assign bus.pronto      = (estado_q == Pronto);
    assign bus.medindo     = (estado_q == Medindo);
endmodule

// File: tb/tb_medidor_tempo.sv
// Directed bench for medidor_tempo: an arithmetic duration model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_medidor_tempo;
    localparam int unsigned C = 4;

    logic clock;
    logic reset;
    medidor_tempo_if bus ();

    medidor_tempo #(
        .CICLOS_METRO(C)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vetores = 0;
    int erros   = 0;
    bit chk_en  = 1'b0;

    task automatic comparar(input string nome, input logic [31:0] atual,
                            input logic [31:0] esperado);
        vetores++;
        if (atual !== esperado) begin
            erros++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Model: count held cycles as a plain integer, derive the result by division.
    int         m_fase;  // 0 idle, 1 measuring, 2 result just published
    int         m_n;
    logic [3:0] m_tempo, m_baixo;
    logic       m_meio;

    function automatic int efetivo(input int n);
        return (n > 15 * C) ? 15 * C : n;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_fase  <= 0;
            m_n     <= 0;
            m_tempo <= '0;
            m_baixo <= '0;
            m_meio  <= 1'b0;
        end else begin
            case (m_fase)
                0: if (bus.iniciar) begin
                    m_fase <= 1;
                    m_n    <= 0;
                end
                1: if (bus.tecla_ativa) begin
                    m_n <= m_n + 1;
                end else begin
                    m_baixo <= 4'(efetivo(m_n) / C);
                    m_tempo <= 4'((efetivo(m_n) + C - 1) / C);
                    m_meio  <= (efetivo(m_n) % C) >= (C / 2);
                    m_fase  <= 2;
                end
                default: m_fase <= 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            comparar("modelo.tempo", 32'(bus.tempo), 32'(m_tempo));
            comparar("modelo.tempo_baixo", 32'(bus.tempo_baixo), 32'(m_baixo));
            comparar("modelo.meio_metro", 32'(bus.meio_metro), 32'(m_meio));
            comparar("modelo.pronto", 32'(bus.pronto), 32'(m_fase == 2));
            comparar("modelo.medindo", 32'(bus.medindo), 32'(m_fase == 1));
        end
    end

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    // Start, hold for n counted cycles (optionally pulsing iniciar mid-count), release.
    task automatic medir(input int n, input int pulso_em);
        bus.iniciar     = 1'b1;
        bus.tecla_ativa = 1'b1;
        passo();
        for (int i = 0; i < n; i++) begin
            bus.iniciar = (i == pulso_em);
            passo();
        end
        bus.iniciar     = 1'b0;
        bus.tecla_ativa = 1'b0;
        passo();
    endtask

    task automatic resultado(input string nome, input int t, input int b, input int m);
        comparar({nome, ".pronto"}, 32'(bus.pronto), 32'd1);
        comparar({nome, ".tempo"}, 32'(bus.tempo), 32'(t));
        comparar({nome, ".tempo_baixo"}, 32'(bus.tempo_baixo), 32'(b));
        comparar({nome, ".meio_metro"}, 32'(bus.meio_metro), 32'(m));
        passo();
        comparar({nome, ".pronto_cai"}, 32'(bus.pronto), 32'd0);
        comparar({nome, ".tempo_mantem"}, 32'(bus.tempo), 32'(t));
    endtask

    initial begin
        reset           = 1'b1;
        bus.iniciar     = 1'b0;
        bus.tecla_ativa = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.iniciar     = 1'($urandom);
            bus.tecla_ativa = 1'($urandom);
            passo();
            chk_en = 1'b1;
        end
        comparar("reset.tempo", 32'(bus.tempo), 32'd0);
        comparar("reset.tempo_baixo", 32'(bus.tempo_baixo), 32'd0);
        comparar("reset.meio_metro", 32'(bus.meio_metro), 32'd0);
        comparar("reset.pronto", 32'(bus.pronto), 32'd0);
        comparar("reset.medindo", 32'(bus.medindo), 32'd0);
        reset           = 1'b0;
        bus.iniciar     = 1'b0;
        bus.tecla_ativa = 1'b0;
        passo();

        medir(10, -1);
        resultado("meio_acima", 3, 2, 1);
        medir(8, -1);
        resultado("exato", 2, 2, 0);
        medir(5, -1);
        resultado("abaixo_meio", 2, 1, 0);
        medir(100, -1);
        resultado("saturacao", 15, 15, 0);

        // Key already released when the measurement starts.
        bus.iniciar     = 1'b1;
        bus.tecla_ativa = 1'b0;
        passo();
        bus.iniciar = 1'b0;
        comparar("zero.medindo", 32'(bus.medindo), 32'd1);
        comparar("zero.pronto_cedo", 32'(bus.pronto), 32'd0);
        passo();
        resultado("zero", 0, 0, 0);

        medir(10, 3);
        resultado("iniciar_ignorado", 3, 2, 1);

        // Previous result stays visible while the next measurement runs.
        bus.iniciar     = 1'b1;
        bus.tecla_ativa = 1'b1;
        passo();
        bus.iniciar = 1'b0;
        passo();
        passo();
        comparar("mantem.medindo", 32'(bus.medindo), 32'd1);
        comparar("mantem.tempo", 32'(bus.tempo), 32'd3);
        comparar("mantem.tempo_baixo", 32'(bus.tempo_baixo), 32'd2);
        comparar("mantem.meio_metro", 32'(bus.meio_metro), 32'd1);
        bus.tecla_ativa = 1'b0;
        passo();
        resultado("dois_ciclos", 1, 0, 1);

        // Reset in the middle of a measurement.
        bus.iniciar     = 1'b1;
        bus.tecla_ativa = 1'b1;
        passo();
        bus.iniciar = 1'b0;
        for (int i = 0; i < 6; i++) passo();
        reset = 1'b1;
        passo();
        comparar("reset_meio.tempo", 32'(bus.tempo), 32'd0);
        comparar("reset_meio.tempo_baixo", 32'(bus.tempo_baixo), 32'd0);
        comparar("reset_meio.meio_metro", 32'(bus.meio_metro), 32'd0);
        comparar("reset_meio.medindo", 32'(bus.medindo), 32'd0);
        reset           = 1'b0;
        bus.tecla_ativa = 1'b0;
        for (int i = 0; i < 3; i++) begin
            passo();
            comparar("reset_meio.sem_pronto", 32'(bus.pronto), 32'd0);
        end
        medir(5, -1);
        resultado("apos_reset", 2, 1, 0);

        passo();
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end
endmodule

// File: doc/medidor_tempo.md
# medidor_tempo

Measures how long the player holds a note key and reports the duration in metronome units. It sits directly upstream of the tempo comparator. It produces the registered `tempo` (rounded up), `tempo_baixo` (rounded down) and `meio_metro` values that the comparator checks against the stored note duration. The main control unit starts a measurement on a key press and consumes the `pronto` pulse.

## Interface
- `CICLOS_METRO`, default 1000: clock cycles per metronome unit; must be ≥ 2 and even.
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; the only reset.
- `iniciar` in 1: start request; honoured only in OCIOSO.
- `tecla_ativa` in 1: level, high while any note key is held.
- `tempo` out 4: duration rounded up, in units.
- `tempo_baixo` out 4: duration rounded down (completed units).
- `meio_metro` out 1: the last partial unit reached at least half a unit.
- `pronto` out 1: one-cycle pulse when the outputs are updated.
- `medindo` out 1: high while in MEDINDO.

## Operation
- State machine states: OCIOSO, MEDINDO, PRONTO.
- OCIOSO:
  - `iniciar`=1 → MEDINDO.
  - `ciclos` (width clog2(CICLOS_METRO)) cleared to 0.
  - `unidades` (4 bits) cleared to 0.
  - `sat` cleared to 0.
  - Otherwise the state holds.
- MEDINDO, `tecla_ativa`=1, one count per cycle:
  - If `sat`=1: nothing changes.
  - Else if `ciclos`=CICLOS_METRO−1: `ciclos`←0.
    - If `unidades`=14: `unidades`←15 and `sat`←1.
    - Otherwise `unidades`←`unidades`+1.
  - Else `ciclos`←`ciclos`+1.
- MEDINDO, `tecla_ativa`=0:
  - The cycle is not counted.
  - Outputs are loaded from the current counters; the state goes to PRONTO.
  - `tempo_baixo`←`unidades`.
  - `tempo`←`unidades`+1 if `ciclos`≠0 and `sat`=0, else `unidades` (saturates at 15, never wraps).
  - `meio_metro`←1 iff `ciclos` ≥ CICLOS_METRO/2 and `sat`=0.
- PRONTO: `pronto`=1 for exactly this cycle, then → OCIOSO unconditionally.
- `iniciar` in MEDINDO or PRONTO: ignored, with no restart.
- Output registers are never cleared at the start of a measurement. They hold the last result until the next PRONTO update or reset.
- A measurement of 0 counted cycles (key already released on the first MEDINDO cycle) gives `tempo`=0, `tempo_baixo`=0, `meio_metro`=0, with a normal `pronto` pulse.
- `iniciar`=1 together with `tecla_ativa`=0 in OCIOSO is still accepted, giving the 0-cycle case above.

## Timing
- Reset values: state OCIOSO, `tempo`=0, `tempo_baixo`=0, `meio_metro`=0, `pronto`=0, `medindo`=0, all counters 0.
- Edge-by-edge sequence:
  - `iniciar` sampled at edge E0 → MEDINDO from E0.
  - Counting covers each later edge with `tecla_ativa`=1.
  - The first edge Er where `tecla_ativa`=0 loads the outputs and enters PRONTO.
  - `pronto` and the new outputs are visible after Er; `pronto` drops after Er+1.
- Latency from release to valid outputs: 1 edge. A measurement with N counted cycles occupies N+1 cycles in MEDINDO.
- `medindo` and `pronto` are decoded directly from the state register, so there is no extra delay.
- `reset` during MEDINDO or PRONTO forces the reset values at the next edge and aborts any `pronto` pulse. Reset has priority over every other input.

## Test plan
All scenarios use CICLOS_METRO=4.
- Reset: assert `reset` with random inputs for 3 cycles → all outputs 0, `medindo`=0.
- Mid-unit release above half: `iniciar` pulse, hold `tecla_ativa` 10 counted cycles, release → `tempo_baixo`=2, `tempo`=3, `meio_metro`=1, `pronto` high exactly 1 cycle.
- Exact units and below half:
  - Hold 8 counted cycles → 2/2/0.
  - Hold 5 counted cycles → `tempo_baixo`=1, `tempo`=2, `meio_metro`=0.
- Saturation: hold 100 counted cycles → `tempo`=15, `tempo_baixo`=15, `meio_metro`=0, no wrap.
- Edge cases:
  - `iniciar` with `tecla_ativa`=0 → 0/0/0 plus a `pronto` pulse 2 cycles after `iniciar`.
  - `iniciar` pulsed during MEDINDO → count unaffected.
  - Outputs hold after PRONTO and through the next MEDINDO.
- Reset mid-measurement: reset after 6 counted cycles → outputs 0 immediately.
  - A `tecla_ativa` release afterwards produces no `pronto`.
  - A new `iniciar` then measures correctly from 0.
